// File: rtl/game_status_packetizer.sv
// game_status_packetizer: queues game events and streams them to the MCU as 4-byte checksummed frames
module game_status_packetizer #(
    parameter int unsigned EVENT_FIFO_DEPTH = 8,
    parameter logic [7:0]  HEADER_BYTE      = 8'hA5,
    parameter int unsigned HEARTBEAT_PERIOD = 64
) (
    input  logic                              game_clk,
    input  logic                              reset_n,
    input  logic                              piece_locked,
    input  logic [2:0]                        lines_cleared,
    input  logic                              game_over,
    input  logic                              piece_request,
    input  logic                              tx_ready,
    output logic [7:0]                        tx_byte,
    output logic                              tx_valid,
    output logic                              tx_frame_start,
    output logic                              overflow,
    output logic [$clog2(EVENT_FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(EVENT_FIFO_DEPTH);
    localparam int HW = HEARTBEAT_PERIOD > 1 ? $clog2(HEARTBEAT_PERIOD) : 1;
    localparam int HB_LAST = HEARTBEAT_PERIOD > 0 ? HEARTBEAT_PERIOD - 1 : 0;
    localparam logic [AW:0] FULL_LVL = EVENT_FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {IDLE, HDR, TYPE, PAY, CSUM} state_t;

    state_t        state;
    logic [11:0]   mem [EVENT_FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [11:0]   frame;
    logic [3:0]    seq;
    logic          pend_go, pend_lk, pend_pr, pend_hb;
    logic [7:0]    pay_go, pay_lk, pay_hb, total_lines, hb_count;
    logic [HW-1:0] hb_timer;
    logic          go_q;
    logic          fire_go, fire_hb, push, pop;
    logic          push_go, push_lk, push_pr, push_hb;
    logic [7:0]    total_nxt, lk_sat, type_byte;
    logic [8:0]    lk_sum;
    logic [11:0]   push_entry;

    assign fifo_level = wr_ptr - rd_ptr;

    always_comb begin
        fire_go    = game_over & ~go_q;
        fire_hb    = HEARTBEAT_PERIOD != 0 && hb_timer == HW'(HB_LAST);
        total_nxt  = total_lines + (piece_locked ? {5'd0, lines_cleared} : 8'd0);
        lk_sum     = {1'b0, pay_lk} + {6'd0, lines_cleared};
        lk_sat     = lk_sum[8] ? 8'hFF : lk_sum[7:0];
        push       = (pend_go | pend_lk | pend_pr | pend_hb) && fifo_level != FULL_LVL;
        pop        = state == IDLE && fifo_level != '0;
        push_go    = push & pend_go;
        push_lk    = push & ~pend_go & pend_lk;
        push_pr    = push & ~pend_go & ~pend_lk & pend_pr;
        push_hb    = push & ~pend_go & ~pend_lk & ~pend_pr;
        push_entry = pend_go ? {4'h2, pay_go} :
                     pend_lk ? {4'h1, pay_lk} :
                     pend_pr ? {4'h3, 8'h00}  : {4'h4, pay_hb};
        type_byte  = {seq, frame[11:8]};
    end

    // A source that fires on the edge its entry is pushed starts a fresh pending entry.
    always_ff @(posedge game_clk) begin
        if (!reset_n) begin
            {pend_go, pend_lk, pend_pr, pend_hb} <= '0;
            {pay_go, pay_lk, pay_hb}             <= '0;
            total_lines                          <= '0;
            hb_count                             <= '0;
            hb_timer                             <= '0;
            go_q                                 <= 1'b0;
            overflow                             <= 1'b0;
        end else begin
            go_q        <= game_over;
            total_lines <= total_nxt;
            hb_timer    <= (HEARTBEAT_PERIOD == 0 || fire_hb) ? '0 : hb_timer + 1'b1;
            if (fire_hb)
                hb_count <= hb_count + 1'b1;
            if (fire_go) begin
                if (pend_go && !push_go) overflow <= 1'b1;
                else begin
                    pend_go <= 1'b1;
                    pay_go  <= total_nxt;
                end
            end else if (push_go) pend_go <= 1'b0;
            if (piece_locked) begin
                if (pend_lk && !push_lk) begin
                    overflow <= 1'b1;
                    pay_lk   <= lk_sat;
                end else begin
                    pend_lk <= 1'b1;
                    pay_lk  <= {5'd0, lines_cleared};
                end
            end else if (push_lk) pend_lk <= 1'b0;
            if (piece_request) begin
                if (pend_pr && !push_pr) overflow <= 1'b1;
                else pend_pr <= 1'b1;
            end else if (push_pr) pend_pr <= 1'b0;
            if (fire_hb) begin
                if (pend_hb && !push_hb) overflow <= 1'b1;
                else begin
                    pend_hb <= 1'b1;
                    pay_hb  <= hb_count;
                end
            end else if (push_hb) pend_hb <= 1'b0;
        end
    end

    always_ff @(posedge game_clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge game_clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_entry;
    end

    always_ff @(posedge game_clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            frame          <= '0;
            seq            <= '0;
            tx_byte        <= '0;
            tx_valid       <= 1'b0;
            tx_frame_start <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    frame          <= mem[rd_ptr[AW-1:0]];
                    state          <= HDR;
                    tx_byte        <= HEADER_BYTE;
                    tx_valid       <= 1'b1;
                    tx_frame_start <= 1'b1;
                end
                HDR: if (tx_ready) begin
                    state          <= TYPE;
                    tx_byte        <= type_byte;
                    tx_frame_start <= 1'b0;
                end
                TYPE: if (tx_ready) begin
                    state   <= PAY;
                    tx_byte <= frame[7:0];
                end
                PAY: if (tx_ready) begin
                    state   <= CSUM;
                    tx_byte <= HEADER_BYTE ^ type_byte ^ frame[7:0];
                end
                CSUM: if (tx_ready) begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    seq      <= seq + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
